// File: rtl/ad9252_pkg.sv
// ad9252_pkg: shared constants and types for the AD9252 transmit emulator
package ad9252_pkg;
  localparam int FRAME_BITS = 14;
  localparam logic [2:0] MODE_EXT    = 3'd0;
  localparam logic [2:0] MODE_MID    = 3'd1;
  localparam logic [2:0] MODE_POS    = 3'd2;
  localparam logic [2:0] MODE_NEG    = 3'd3;
  localparam logic [2:0] MODE_CHECK  = 3'd4;
  localparam logic [2:0] MODE_TOGGLE = 3'd5;
  localparam logic [2:0] MODE_USER   = 3'd6;
  localparam logic [2:0] MODE_RAMP   = 3'd7;
  localparam logic [FRAME_BITS-1:0] MIDSCALE  = 14'h2000;
  localparam logic [FRAME_BITS-1:0] POS_FS    = 14'h3FFF;
  localparam logic [FRAME_BITS-1:0] NEG_FS    = 14'h0000;
  localparam logic [FRAME_BITS-1:0] CHECKER_A = 14'h2AAA;
  localparam logic [FRAME_BITS-1:0] CHECKER_B = 14'h1555;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [3:0] clamp_skew(input logic [3:0] s);
    return s > 4'(FRAME_BITS - 1) ? 4'(FRAME_BITS - 1) : s;
  endfunction
endpackage

// File: rtl/ad9252_tx_lane.sv
// ad9252_tx_lane: one serial lane -- frame word select, serializer, ramp, skew history
module ad9252_tx_lane
  import ad9252_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  run,
  input  logic [2:0]            mode,
  input  logic                  chk_phase,
  input  logic                  tog_phase,
  input  logic                  cap,
  input  logic [FRAME_BITS-1:0] user_pattern,
  input  logic [FRAME_BITS-1:0] sample,
  input  logic [3:0]            skew,
  output logic                  data
);
  logic [FRAME_BITS-1:0] word, word_n, sr, ramp;
  logic [2*FRAME_BITS-1:0] hist, hist_n;
  logic [3:0] skew_q, skew_n;
  logic bit_n;
  // next frame word, next undelayed bit and the shifted skew history
  always_comb begin
    word_n = mode == MODE_EXT ? (cap ? sample : word)
           : mode == MODE_MID ? MIDSCALE
           : mode == MODE_POS ? POS_FS
           : mode == MODE_NEG ? NEG_FS
           : mode == MODE_CHECK ? (chk_phase ? CHECKER_B : CHECKER_A)
           : mode == MODE_TOGGLE ? (tog_phase ? NEG_FS : POS_FS)
           : mode == MODE_USER ? user_pattern
           : ramp;
    bit_n = run && (load ? word_n[FRAME_BITS-1] : sr[FRAME_BITS-2]);
    hist_n = run ? {hist[2*FRAME_BITS-2:0], bit_n} : '0;
    skew_n = load ? clamp_skew(skew) : skew_q;
  end
  // word/serializer/ramp update at frame boundaries; output taps the history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= '0;
      sr <= '0;
      ramp <= '0;
      hist <= '0;
      skew_q <= '0;
      data <= 1'b0;
    end else begin
      word <= load ? word_n : word;
      sr <= load ? word_n : sr << 1;
      ramp <= ramp + FRAME_BITS'(load && mode == MODE_RAMP);
      hist <= hist_n;
      skew_q <= skew_n;
      data <= hist_n[{1'b0, skew_n}];
    end
endmodule

// File: rtl/ad9252_tx_emu.sv
// ad9252_tx_emu: AD9252 serial LVDS transmit-side emulator (DCO, FCO, per-lane data)
module ad9252_tx_emu
  import ad9252_pkg::*;
#(
  parameter int ADC_CHANEL = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [2:0]                       pattern_sel,
  input  logic [FRAME_BITS-1:0]            user_pattern,
  input  logic [4*ADC_CHANEL-1:0]          bit_skew,
  input  logic [FRAME_BITS*ADC_CHANEL-1:0] sample_data,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  output logic                             dco_out,
  output logic                             fco_out,
  output logic [ADC_CHANEL-1:0]            data_out,
  output logic [15:0]                      frame_cnt,
  output logic                             underrun
);
  state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [2:0] mode;
  logic chk_phase, tog_phase, load, frame_done, cap, dco_n, fco_n, ready_n;
  // state and frame-timing registers plus registered outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      mode <= MODE_EXT;
      chk_phase <= 1'b0;
      tog_phase <= 1'b0;
      dco_out <= 1'b0;
      fco_out <= 1'b0;
      sample_ready <= 1'b0;
      underrun <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      mode <= load ? pattern_sel : mode;
      chk_phase <= chk_phase ^ (load && pattern_sel == MODE_CHECK);
      tog_phase <= tog_phase ^ (load && pattern_sel == MODE_TOGGLE);
      dco_out <= dco_n;
      fco_out <= fco_n;
      sample_ready <= ready_n;
      underrun <= sample_ready && !sample_valid;
      frame_cnt <= frame_cnt + 16'(frame_done);
    end
  // run/idle decided only at frame boundaries; bit counter moves only in RUN
  always_comb begin
    frame_done = state == RUN && bit_cnt == 4'(FRAME_BITS - 1);
    state_n = state == IDLE ? (enable ? RUN : IDLE) : (frame_done && !enable ? IDLE : RUN);
    bit_cnt_n = state == RUN && !frame_done ? bit_cnt + 4'd1 : 4'd0;
    load = state_n == RUN && (state == IDLE || frame_done);
  end
  // next-cycle clock/frame/handshake outputs derived from the next bit position
  always_comb begin
    dco_n = state_n == RUN && !bit_cnt_n[0];
    fco_n = state_n == RUN && bit_cnt_n < 4'(FRAME_BITS / 2);
    ready_n = state_n == RUN && bit_cnt_n == 4'(FRAME_BITS - 1) && mode == MODE_EXT;
    cap = sample_ready && sample_valid;
  end
  for (genvar i = 0; i < ADC_CHANEL; i++) begin : g_lane
    ad9252_tx_lane u_lane (
      .clk(clk),
      .rst_n(reset_n),
      .load(load),
      .run(state_n == RUN),
      .mode(pattern_sel),
      .chk_phase(chk_phase),
      .tog_phase(tog_phase),
      .cap(cap),
      .user_pattern(user_pattern),
      .sample(sample_data[FRAME_BITS*i +: FRAME_BITS]),
      .skew(bit_skew[4*i +: 4]),
      .data(data_out[i])
    );
  end
endmodule

// File: doc/ad9252_tx_emu.md
# ad9252_tx_emu

Digital emulator of the AD9252 serial LVDS output side: it produces DCO, FCO and per-channel serial data streams (14-bit frames, MSB first, DDR on DCO) from parallel samples or built-in test patterns. It drives the ADC receive path in simulation and on-board loopback. Per-channel programmable bit skew exercises the receiver's DCO/FCO alignment, bitslip and data-delay FSMs. Single-ended outputs; differential buffers live outside this block.

## Interface
- ADC_CHANEL, 4: number of serial data lanes.
- FRAME_BITS, 14: bits per frame; fixed at 14, kept as a named constant.
- clk  in  1: bit-rate clock; one data bit per cycle (DCO = clk/2).
- reset_n  in  1: one clock; reset is asynchronous and active-low.
- enable  in  1: run emulator.
- pattern_sel  in  3: 0 external, 1 midscale, 2 +FS, 3 -FS, 4 checkerboard, 5 word toggle, 6 user, 7 ramp.
- user_pattern  in  14: word for mode 6.
- bit_skew  in  4*ADC_CHANEL: per-lane data delay in bits vs FCO, 0..13.
- sample_data  in  14*ADC_CHANEL: lane i at [14*i+13:14*i].
- sample_valid  in  1: sample_data holds a valid frame.
- sample_ready  out  1: frame load strobe (mode 0 only).
- dco_out  out  1: bit clock.
- fco_out  out  1: frame clock.
- data_out  out  ADC_CHANEL: serial data.
- frame_cnt  out  16: completed frames, wraps.
- underrun  out  1: one-cycle pulse, frame loaded without valid data.

## Operation
- bit_cnt 0..13 advances each clk while running; bit_cnt 13 is the frame boundary.
- States: IDLE (bit_cnt held 0, dco/fco/data 0) -> RUN when enable=1; enable=0 in RUN finishes the current frame, returns to IDLE after bit_cnt 13. enable=1 again in that last frame keeps RUN.
- dco_out toggles every RUN cycle; 1 at even bit_cnt. Data edge-aligned to both DCO edges.
- fco_out = 1 for bit_cnt 0..6, 0 for 7..13.
- Frame word: mode 0 sample_data; 1 0x2000; 2 0x3FFF; 3 0x0000; 4 0x2AAA/0x1555 alternating per frame starting 0x2AAA; 5 0x3FFF/0x0000 alternating starting 0x3FFF; 6 user_pattern; 7 ramp, per-lane counter starting 0, +1 per frame, wraps 0x3FFF->0x0000.
- Mode 0: sample_ready high during bit_cnt 13 of RUN; valid high then -> word captured; valid low -> previous word repeated, underrun pulses next cycle.
- pattern_sel, user_pattern, bit_skew sampled only at frame boundary; mid-frame changes never corrupt a frame.
- Skew: each lane keeps a 28-bit history of its undelayed stream; data_out[i] = history tap bit_skew[i]. Values 14/15 clamp to 13. History flushes to 0 on IDLE entry.
- frame_cnt increments at each completed frame, 0xFFFF -> 0x0000.

## Timing
- Reset: all outputs 0, bit_cnt 0, state IDLE, ramps 0, checkerboard/toggle phase to first value, history 0.
- IDLE->RUN: enable sampled high at edge N; cycle after N is bit_cnt 0, with fco_out=1 and dco_out=1.
- Latency: word captured at end of bit_cnt 13 drives its bit 13 during the next bit_cnt 0 (skew 0); bit k in bit_cnt 13-k.
- Skew s shifts the lane stream s cycles later; FCO/DCO unaffected.
- Async reset mid-frame: outputs 0 immediately; after release, first frame only after enable is sampled.
- All outputs registered; no combinational path input->output.

## Structure
- Package ad9252_pkg: FRAME_BITS, mode constants (MODE_EXT..MODE_RAMP), pattern words (MIDSCALE, POS_FS, NEG_FS, CHECKER_A/B).
- Sub-module ad9252_tx_lane: per-lane word register, serializer shift register, ramp counter, 28-bit skew history; top holds bit_cnt, FSM, DCO/FCO, handshake, frame_cnt; lanes via generate.

## Test plan
- Mode 1, skew 0, enable after reset: each lane's 14 bits after FCO rise = 0x2000; fco 7 high/7 low; dco toggles every cycle.
- Mode 0, sample_valid=1, lane0 0x1234, lane3 0x3ABC: next frame deserializes to those; sample_ready high only at bit_cnt 13.
- Mode 0, sample_valid low one boundary: previous word repeated, underrun one pulse, frame_cnt still increments.
- Mode 7, lane1 skew 5: lane1 stream equals lane0 delayed 5 cycles; ramp 0,1,2,...; force 0x3FFF -> next 0x0000.
- Switch mode 4->2 at bit_cnt 6: current frame completes as checkerboard, next is 0x3FFF; skew 15 behaves as 13.
- enable low at bit_cnt 3: frame completes, outputs 0 from next cycle; reset_n low mid-frame: all outputs 0 asynchronously, frame_cnt 0.
